// File: rtl/alu_bk_pkg.sv
`default_nettype none
// ============================================================================
// Package   : alu_bk_pkg
// Purpose   : Shared types and the group generate/propagate merge operator
//             used by the black and gray cells of the Brent-Kung prefix tree
//             in the 4-bit ALU adder.
// Contents  : ALU_WIDTH - adder width
//             pg_t      - packed {g, p} group pair
//             pg_merge  - merges a higher (hi) group with the adjacent lower
//                         (lo) group
// Revision  : 1.0 - initial release
// ============================================================================
package alu_bk_pkg;

   localparam int ALU_WIDTH = 4;

   typedef struct packed {
      logic g;
      logic p;
   } pg_t;

   // Argument order matters: the operator is associative but not
   // commutative, and hi must be the more significant group.
   function automatic pg_t pg_merge(input pg_t hi, input pg_t lo);
      pg_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bk_pg_merge.sv
`default_nettype none
// ============================================================================
// Module    : bk_pg_merge
// Purpose   : Single-lane combinational group generate/propagate merge.
// Ports     : gi, pi - generate/propagate of the higher-significance group
//             gk, pk - generate/propagate of the lower-significance group
//             go, po - merged group generate/propagate
// Revision  : 1.0 - initial release
// ============================================================================
module bk_pg_merge
   import alu_bk_pkg::*;
(
   input  logic gi,
   input  logic pi,
   input  logic gk,
   input  logic pk,
   output logic go,
   output logic po
);

   pg_t w_hi;
   pg_t w_lo;
   pg_t w_res;

   assign w_hi  = '{g: gi, p: pi};
   assign w_lo  = '{g: gk, p: pk};
   assign w_res = pg_merge(w_hi, w_lo);

   assign go = w_res.g;
   assign po = w_res.p;

endmodule
`default_nettype wire

// File: rtl/black_cell_impar.sv
`default_nettype none
// ============================================================================
// Module    : black_cell_impar
// Purpose   : Odd-position black cell of the Brent-Kung prefix tree. Merges
//             the higher (i) group pair with the adjacent lower (k) group
//             pair over WIDTH independent lanes, with a valid qualifier.
// Ports     : clk       - clock, rising edge
//             rst_n     - asynchronous active-low reset
//             in_valid  - operand set valid this cycle
//             Gi, Pi    - higher-significance group generate/propagate
//             Gk, Pk    - lower-significance group generate/propagate
//             out_valid - Go/Po are meaningful
//             Go, Po    - merged group generate/propagate
// Parameter : WIDTH     - number of independent lanes (>= 1)
// Macro     : BLACK_CELL_IMPAR_PIPE_EN - when defined, Go/Po/out_valid are
//             registered (1-cycle latency); otherwise the cell is purely
//             combinational and clk/rst_n are unused.
// Revision  : 1.0 - initial release
// ============================================================================
module black_cell_impar
   import alu_bk_pkg::*;
#(
   parameter int WIDTH = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] Gi,
   input  logic [WIDTH-1:0] Pi,
   input  logic [WIDTH-1:0] Gk,
   input  logic [WIDTH-1:0] Pk,
   output logic             out_valid,
   output logic [WIDTH-1:0] Go,
   output logic [WIDTH-1:0] Po
);

   logic [WIDTH-1:0] w_go;
   logic [WIDTH-1:0] w_po;

   generate
      for (genvar n = 0; n < WIDTH; n++) begin : g_lane
         bk_pg_merge u_merge (
            .gi (Gi[n]),
            .pi (Pi[n]),
            .gk (Gk[n]),
            .pk (Pk[n]),
            .go (w_go[n]),
            .po (w_po[n])
         );
      end
   endgenerate

`ifdef BLACK_CELL_IMPAR_PIPE_EN
   logic             r_valid;
   logic [WIDTH-1:0] r_go;
   logic [WIDTH-1:0] r_po;

   // Data is captured regardless of in_valid; out_valid qualifies it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_go    <= '0;
         r_po    <= '0;
      end else begin
         r_valid <= in_valid;
         r_go    <= w_go;
         r_po    <= w_po;
      end
   end

   assign out_valid = r_valid;
   assign Go        = r_go;
   assign Po        = r_po;
`else
   // clk and rst_n are kept as ports so both builds share one footprint.
   logic w_unused_clk_rst;
   assign w_unused_clk_rst = clk & rst_n;

   assign out_valid = in_valid;
   assign Go        = w_go;
   assign Po        = w_po;
`endif

endmodule
`default_nettype wire

// File: tb/tb_black_cell_impar.sv
`default_nettype none
// ============================================================================
// Module    : tb_black_cell_impar
// Purpose   : Self-checking bench for black_cell_impar. A WIDTH=1 and a
//             WIDTH=4 instance share clock, reset and in_valid; expected
//             results are queued when stimulus is applied and compared when
//             the DUT output is due (same cycle combinational, next edge
//             when BLACK_CELL_IMPAR_PIPE_EN is defined).
// Revision  : 1.0 - initial release
// ============================================================================
module tb_black_cell_impar;

`ifdef BLACK_CELL_IMPAR_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   typedef struct packed {
      logic       v;
      logic       g1;
      logic       p1;
      logic [3:0] g4;
      logic [3:0] p4;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       gi1, pi1, gk1, pk1;
   logic       go1, po1, ov1;
   logic [3:0] gi4, pi4, gk4, pk4;
   logic [3:0] go4, po4;
   logic       ov4;

   exp_t sb[$];
   int   n_checks     = 0;
   int   n_errors     = 0;
   int   n_valid_exp  = 0;
   int   n_valid_seen = 0;

   always #5 clk = ~clk;

   black_cell_impar #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .Gi        (gi1),
      .Pi        (pi1),
      .Gk        (gk1),
      .Pk        (pk1),
      .out_valid (ov1),
      .Go        (go1),
      .Po        (po1)
   );

   black_cell_impar #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .Gi        (gi4),
      .Pi        (pi4),
      .Gk        (gk4),
      .Pk        (pk4),
      .out_valid (ov4),
      .Go        (go4),
      .Po        (po4)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference equations, evaluated on the currently applied inputs.
   function automatic exp_t model();
      exp_t e;
      e.v  = in_valid;
      e.g1 = gi1 | (pi1 & gk1);
      e.p1 = pi1 & pk1;
      e.g4 = gi4 | (pi4 & gk4);
      e.p4 = pi4 & pk4;
      return e;
   endfunction

   // A registered build captures nothing while rst_n is low.
   task automatic push_exp(input exp_t e_in);
      exp_t e;
      e = e_in;
      if (PIPE && !rst_n) e = '0;
      if (e.v) n_valid_exp++;
      sb.push_back(e);
   endtask

   // v1 = {Gi,Pi,Gk,Pk} for the 1-lane DUT.
   task automatic drive(input logic rst, input logic vld, input logic [3:0] v1,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
      @(negedge clk);
      rst_n    = rst;
      in_valid = vld;
      {gi1, pi1, gk1, pk1} = v1;
      gi4 = a;
      pi4 = b;
      gk4 = c;
      pk4 = d;
   endtask

   task automatic drive_rand(input logic rst, input logic vld, input logic [3:0] v1);
      drive(rst, vld, v1, 4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), 4'($urandom_range(15)));
   endtask

   task automatic compare();
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("out_valid_w1", 32'(ov1), 32'(e.v));
         check("go_w1",        32'(go1), 32'(e.g1));
         check("po_w1",        32'(po1), 32'(e.p1));
         check("out_valid_w4", 32'(ov4), 32'(e.v));
         check("go_w4",        32'(go4), 32'(e.g4));
         check("po_w4",        32'(po4), 32'(e.p4));
         if (ov1) n_valid_seen++;
      end
   endtask

`ifdef BLACK_CELL_IMPAR_PIPE_EN
   always @(posedge clk) begin
      #1;
      compare();
   end
`else
   always @(negedge clk) begin
      #2;
      compare();
   end
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] spot_vec [4];
      logic       spot_g   [4];
      logic       spot_p   [4];
      exp_t       e;

      spot_vec = '{4'b0110, 4'b0101, 4'b1111, 4'b0011};
      spot_g   = '{1'b1,    1'b0,    1'b1,    1'b0};
      spot_p   = '{1'b0,    1'b1,    1'b1,    1'b0};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      {gi1, pi1, gk1, pk1} = 4'b0000;
      gi4 = '0; pi4 = '0; gk4 = '0; pk4 = '0;

      // Reset state before any clock edge.
      #2;
      check("reset_ov1", 32'(ov1), 32'd0);
      check("reset_go1", 32'(go1), 32'd0);
      check("reset_po1", 32'(po1), 32'd0);
      check("reset_ov4", 32'(ov4), 32'd0);
      check("reset_go4", 32'(go4), 32'd0);
      check("reset_po4", 32'(po4), 32'd0);

      drive_rand(1'b1, 1'b0, 4'b0000);
      push_exp(model());

      // Exhaustive sweep of the 1-lane operator.
      for (int v = 0; v < 16; v++) begin
         drive_rand(1'b1, 1'b1, 4'(v));
         push_exp(model());
      end

      // Spot checks with literal expectations.
      for (int s = 0; s < 4; s++) begin
         drive_rand(1'b1, 1'b1, spot_vec[s]);
         e    = model();
         e.g1 = spot_g[s];
         e.p1 = spot_p[s];
         push_exp(e);
      end

      // Lane independence on the 4-lane instance.
      drive(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b1110, 4'b0100, 4'b1010);
      e    = model();
      e.g4 = 4'b0101;
      e.p4 = 4'b1010;
      e.g1 = 1'b0;
      e.p1 = 1'b0;
      push_exp(e);

      // Latency: 0111 valid, then the same data with in_valid low.
      drive_rand(1'b1, 1'b1, 4'b0111);
      e    = model();
      e.v  = 1'b1;
      e.g1 = 1'b1;
      e.p1 = 1'b1;
      push_exp(e);
      drive_rand(1'b1, 1'b0, 4'b0111);
      e    = model();
      e.v  = 1'b0;
      push_exp(e);

      // Asynchronous reset between edges while Go=1 and out_valid=1.
      drive_rand(1'b1, 1'b1, 4'b0111);
      push_exp(model());
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_ov1", 32'(ov1), PIPE ? 32'd0 : 32'd1);
      check("async_rst_go1", 32'(go1), PIPE ? 32'd0 : 32'd1);
      check("async_rst_po1", 32'(po1), PIPE ? 32'd0 : 32'd1);
      check("async_rst_ov4", 32'(ov4), PIPE ? 32'd0 : 32'd1);
      drive_rand(1'b0, 1'b1, 4'b1111);
      push_exp(model());
      drive_rand(1'b1, 1'b0, 4'b0000);
      push_exp(model());

      // Streaming with a 2-cycle reset in the middle.
      for (int i = 0; i < 16; i++) begin
         drive_rand((i == 6 || i == 7) ? 1'b0 : 1'b1, 1'b1, 4'(15 - i));
         push_exp(model());
      end

      drive_rand(1'b1, 1'b0, 4'b0000);
      push_exp(model());
      drive_rand(1'b1, 1'b0, 4'b0000);
      push_exp(model());
      @(posedge clk);
      #3;
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      check("valid_output_count", 32'(n_valid_seen), 32'(n_valid_exp));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
